decode_stage: RTL and testbench

Registered, handshaked instruction-decode stage for the RV32I/RV32IM core. It sits between fetch and execute and replaces the purely combinational main decoder. Per instruction it produces:
- the full control bundle,
- the sign-extended immediate,
- register indices,
- an illegal-instruction flag.

It holds results in a two-entry skid buffer so fetch and execute can stall independently. It also keeps a saturating count of illegal instructions for debug.

---
 rtl/core_pkg.sv | 58 +++++
 rtl/decode_stage_if.sv | 48 ++++
 rtl/decode_logic.sv | 124 ++++++++++++
 rtl/decode_stage.sv | 127 ++++++++++++
 tb/tb_decode_stage.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared RV32I/RV32IM decode definitions: opcodes, select encodings and the
// control bundle carried from decode to execute.
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;

    // Next-pc select; conditional branches keep PCS_PLUS4 and use the branch flag.
    localparam logic [1:0] PCS_PLUS4 = 2'd0;
    localparam logic [1:0] PCS_JAL   = 2'd1;
    localparam logic [1:0] PCS_JALR  = 2'd2;

    localparam logic [1:0] RD_ALU    = 2'd0;
    localparam logic [1:0] RD_PC4    = 2'd1;
    localparam logic [1:0] RD_PCIMM  = 2'd2;
    localparam logic [1:0] RD_IMM    = 2'd3;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       alu_op;
        logic       alu_add;
        logic       mem_write;
        logic       mem_read;
        logic       result_src;
        logic       branch;
        logic       is_muldiv;
        logic       illegal;
        logic [2:0] imm_src;
        logic [1:0] pc_to_rd;
        logic [1:0] pc_src;
    } ctrl_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side input and execute-side output bundle of the decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
    // Both sides use strict valid/ready: a word moves on a cycle where valid and
    // ready are both high; valid never waits for ready, and payload stays stable
    // while valid is high and ready is low.
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic            out_reg_write;
    logic            out_alu_src;
    logic            out_alu_op;
    logic            out_alu_add;
    logic            out_mem_write;
    logic            out_mem_read;
    logic            out_result_src;
    logic            out_branch;
    logic            out_is_muldiv;
    logic            out_illegal;
    logic [2:0]      out_imm_src;
    logic [1:0]      out_pc_to_rd;
    logic [1:0]      out_pc_src;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2,
               out_funct3, out_reg_write, out_alu_src, out_alu_op, out_alu_add,
               out_mem_write, out_mem_read, out_result_src, out_branch,
               out_is_muldiv, out_illegal, out_imm_src, out_pc_to_rd, out_pc_src
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2,
               out_funct3, out_reg_write, out_alu_src, out_alu_op, out_alu_add,
               out_mem_write, out_mem_read, out_result_src, out_branch,
               out_is_muldiv, out_illegal, out_imm_src, out_pc_to_rd, out_pc_src
    );
endinterface

// File: rtl/decode_logic.sv
// Combinational RV32I(M) main decoder: instruction word to control bundle,
// sign-extended immediate and illegal flag.
module decode_logic
    import core_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        bad;
    logic [31:0] imm32;

    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];
    assign funct3 = instr[14:12];

    always_comb begin
        ctrl = '0;
        bad  = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = 1'b1;
                if (funct7 == F7_ALT)
                    bad = !(funct3 == 3'b000 || funct3 == 3'b101);
                else if (funct7 == F7_MULDIV && ENABLE_M)
                    ctrl.is_muldiv = 1'b1;
                else if (funct7 != F7_BASE)
                    bad = 1'b1;
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = 1'b1;
                if (funct3 == 3'b001) begin
                    ctrl.imm_src = IMM_SHAMT;
                    bad          = funct7 != F7_BASE;
                end else if (funct3 == 3'b101) begin
                    ctrl.imm_src = IMM_SHAMT;
                    bad          = !(funct7 == F7_BASE || funct7 == F7_ALT);
                end
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_add    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.result_src = 1'b1;
                bad = funct3 inside {3'b011, 3'b110, 3'b111};
            end
            OP_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.alu_add   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.imm_src   = IMM_S;
                bad = funct3 > 3'b010;
            end
            OP_BRANCH: begin
                ctrl.branch  = 1'b1;
                ctrl.imm_src = IMM_B;
                bad = funct3 inside {3'b010, 3'b011};
            end
            OP_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm_src   = IMM_J;
                ctrl.pc_to_rd  = RD_PC4;
                ctrl.pc_src    = PCS_JAL;
            end
            OP_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_add   = 1'b1;
                ctrl.pc_to_rd  = RD_PC4;
                ctrl.pc_src    = PCS_JALR;
                bad = funct3 != 3'b000;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_U;
                ctrl.pc_to_rd  = RD_IMM;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_U;
                ctrl.pc_to_rd  = RD_PCIMM;
            end
            default: bad = 1'b1;
        endcase
        if (instr[1:0] != 2'b11)
            bad = 1'b1;
        // Illegal words still travel downstream, but with no architectural side effect.
        if (bad) begin
            ctrl.reg_write = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.branch    = 1'b0;
            ctrl.pc_src    = PCS_PLUS4;
        end
        ctrl.illegal = bad;
    end

    always_comb begin
        case (ctrl.imm_src)
            IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:     imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:     imm32 = {instr[31:12], 12'b0};
            IMM_SHAMT: imm32 = {27'b0, instr[24:20]};
            default:   imm32 = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

    assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder feeding a two-entry skid buffer (M drives the
// output, S catches the word accepted while M is stalled) plus an illegal counter.
module decode_stage
    import core_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    decode_stage_if.slave    bus,
    output logic [CNT_W-1:0] illegal_count,
    output buf_state_t       dbg_state
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        ctrl_t           ctrl;
    } entry_t;

    ctrl_t            dec_ctrl;
    logic [XLEN-1:0]  dec_imm;
    entry_t           in_entry, m_q, m_d, s_q, s_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    buf_state_t       state_q, state_d;
    logic             accept, consume;

    decode_logic #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_decode (
        .instr (bus.in_instr),
        .ctrl  (dec_ctrl),
        .imm   (dec_imm)
    );

    always_comb begin
        in_entry        = '0;
        in_entry.valid  = 1'b1;
        in_entry.pc     = bus.in_pc;
        in_entry.imm    = dec_imm;
        in_entry.rd     = bus.in_instr[11:7];
        in_entry.rs1    = bus.in_instr[19:15];
        in_entry.rs2    = bus.in_instr[24:20];
        in_entry.funct3 = bus.in_instr[14:12];
        in_entry.ctrl   = dec_ctrl;
    end

    // in_ready_q mirrors !S.valid, so an accept never finds both entries occupied.
    assign accept  = bus.in_valid & in_ready_q & ~flush;
    assign consume = m_q.valid & bus.out_ready & ~flush;

    always_comb begin
        m_d   = m_q;
        s_d   = s_q;
        cnt_d = cnt_q;
        if (flush) begin
            m_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end else begin
            if (consume) begin
                if (s_q.valid) begin
                    m_d       = s_q;
                    s_d.valid = 1'b0;
                end else if (accept) begin
                    m_d = in_entry;
                end else begin
                    m_d.valid = 1'b0;
                end
            end else if (accept) begin
                if (m_q.valid) s_d = in_entry;
                else           m_d = in_entry;
            end
            if (accept && dec_ctrl.illegal && cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end
        in_ready_d = ~s_d.valid;
        state_d    = s_d.valid ? BUF_FULL : (m_d.valid ? BUF_ONE : BUF_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= BUF_EMPTY;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    assign bus.in_ready       = in_ready_q & ~flush;
    assign bus.out_valid      = m_q.valid;
    assign bus.out_pc         = m_q.pc;
    assign bus.out_imm        = m_q.imm;
    assign bus.out_rd         = m_q.rd;
    assign bus.out_rs1        = m_q.rs1;
    assign bus.out_rs2        = m_q.rs2;
    assign bus.out_funct3     = m_q.funct3;
    assign bus.out_reg_write  = m_q.ctrl.reg_write;
    assign bus.out_alu_src    = m_q.ctrl.alu_src;
    assign bus.out_alu_op     = m_q.ctrl.alu_op;
    assign bus.out_alu_add    = m_q.ctrl.alu_add;
    assign bus.out_mem_write  = m_q.ctrl.mem_write;
    assign bus.out_mem_read   = m_q.ctrl.mem_read;
    assign bus.out_result_src = m_q.ctrl.result_src;
    assign bus.out_branch     = m_q.ctrl.branch;
    assign bus.out_is_muldiv  = m_q.ctrl.is_muldiv;
    assign bus.out_illegal    = m_q.ctrl.illegal;
    assign bus.out_imm_src    = m_q.ctrl.imm_src;
    assign bus.out_pc_to_rd   = m_q.ctrl.pc_to_rd;
    assign bus.out_pc_src     = m_q.ctrl.pc_src;
    assign illegal_count      = cnt_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed decode vectors, skid-buffer stall and flush
// sequences, then random streaming against a queue model.
module tb_decode_stage;
    import core_pkg::*;

    localparam int XLEN = 32;
    localparam int W    = 64;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  imm_src;
        logic [1:0]  pc_src;
        logic [1:0]  pc_to_rd;
        logic        rw;
        logic        mw;
        logic        br;
        logic        md;
        logic        ill_a;
        logic        ill_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    buf_state_t  state_a, state_b;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_item;
    logic         cur_ill_a, cur_ill_b;
    logic         m_ready;
    int           exp_cnt_a, exp_cnt_b;
    int           n_checks = 0;
    int           n_fail   = 0;
    vec_t         vecs[14];

    decode_stage_if #(.XLEN(XLEN)) bus_a ();
    decode_stage_if #(.XLEN(XLEN)) bus_b ();

    decode_stage #(.XLEN(XLEN), .ENABLE_M(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus_a),
        .illegal_count(cnt_a), .dbg_state(state_a)
    );

    // Second instance without M extension and with a 2-bit counter shares all inputs.
    decode_stage #(.XLEN(XLEN), .ENABLE_M(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus_b),
        .illegal_count(cnt_b), .dbg_state(state_b)
    );

    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.in_instr  = bus_a.in_instr;
    assign bus_b.in_pc     = bus_a.in_pc;
    assign bus_b.out_ready = bus_a.out_ready;

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] exp_imm, input logic ill_a, input logic ill_b);
        bus_a.in_valid = 1'b1;
        bus_a.in_instr = instr;
        bus_a.in_pc    = pc;
        cur_item       = {pc, exp_imm};
        cur_ill_a      = ill_a;
        cur_ill_b      = ill_b;
    endtask

    task automatic idle();
        bus_a.in_valid = 1'b0;
    endtask

    // One clock: predict the handshake, advance the model, then compare both DUTs.
    task automatic cycle();
        logic       acc, con;
        buf_state_t exp_state;
        acc = bus_a.in_valid && m_ready && !flush;
        con = (exp_q.size() > 0) && bus_a.out_ready && !flush;
        @(posedge clk);
        #1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (con) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(cur_item);
                if (cur_ill_a) exp_cnt_a++;
                if (cur_ill_b && exp_cnt_b < 3) exp_cnt_b++;
            end
        end
        m_ready = exp_q.size() < 2;
        flush   = 1'b0;
        #1;
        exp_state = (exp_q.size() == 0) ? BUF_EMPTY : (exp_q.size() == 1) ? BUF_ONE : BUF_FULL;
        check("out_valid", bus_a.out_valid, exp_q.size() > 0);
        check("in_ready", bus_a.in_ready, m_ready);
        check("state", state_a, exp_state);
        check("b_out_valid", bus_b.out_valid, exp_q.size() > 0);
        check("cnt_a", cnt_a, exp_cnt_a);
        check("cnt_b", cnt_b, exp_cnt_b);
        if (exp_q.size() > 0) begin
            check("out_pc", bus_a.out_pc, exp_q[0][63:32]);
            check("out_imm", bus_a.out_imm, exp_q[0][31:0]);
            check("b_out_pc", bus_b.out_pc, exp_q[0][63:32]);
        end
    endtask

    initial begin
        //            instr         imm           src pcs ptr rw mw br md ia ib
        vecs[0]  = '{32'h00500093, 32'h00000005, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h0020A423, 32'h00000008, 3'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h022081B3, 32'h00000022, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{32'h000010E7, 32'h00000000, 3'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{32'h008000EF, 32'h00000008, 3'd3, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h123452B7, 32'h12345000, 3'd4, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h4030D093, 32'h00000003, 3'd5, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h40309093, 32'h00000003, 3'd5, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{32'h00000000, 32'h00000000, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{32'h00003083, 32'h00000000, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{32'h00001117, 32'h00001000, 3'd4, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'hFFF12183, 32'hFFFFFFFF, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        flush = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_a.in_instr = '0;
        bus_a.in_pc = '0;
        bus_a.out_ready = 1'b0;
        cur_item = '0;
        cur_ill_a = 1'b0;
        cur_ill_b = 1'b0;
        m_ready = 1'b0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus_a.in_ready, 1'b0);
        check("rst_out_valid", bus_a.out_valid, 1'b0);
        check("rst_out_pc", bus_a.out_pc, 32'h0);
        check("rst_out_imm", bus_a.out_imm, 32'h0);
        check("rst_out_rd", bus_a.out_rd, 5'd0);
        check("rst_reg_write", bus_a.out_reg_write, 1'b0);
        check("rst_cnt", cnt_a, 16'd0);
        check("rst_state", state_a, BUF_EMPTY);
        rst = 1'b0;
        cycle();

        // Directed decode vectors, streamed back to back with out_ready high.
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].instr, 32'h1000 + 32'(i * 4), vecs[i].imm, vecs[i].ill_a, vecs[i].ill_b);
            cycle();
            check("imm_src", bus_a.out_imm_src, vecs[i].imm_src);
            check("reg_write", bus_a.out_reg_write, vecs[i].rw);
            check("mem_write", bus_a.out_mem_write, vecs[i].mw);
            check("branch", bus_a.out_branch, vecs[i].br);
            check("pc_src", bus_a.out_pc_src, vecs[i].pc_src);
            check("pc_to_rd", bus_a.out_pc_to_rd, vecs[i].pc_to_rd);
            check("is_muldiv", bus_a.out_is_muldiv, vecs[i].md);
            check("illegal", bus_a.out_illegal, vecs[i].ill_a);
            check("b_illegal", bus_b.out_illegal, vecs[i].ill_b);
            check("b_reg_write", bus_b.out_reg_write, vecs[i].rw & ~vecs[i].ill_b);
            if (i == 0) begin
                check("addi_rd", bus_a.out_rd, 5'd1);
                check("addi_rs1", bus_a.out_rs1, 5'd0);
                check("addi_alu_src", bus_a.out_alu_src, 1'b1);
            end
            if (i == 1) begin
                check("sw_rs1", bus_a.out_rs1, 5'd1);
                check("sw_rs2", bus_a.out_rs2, 5'd2);
                check("sw_funct3", bus_a.out_funct3, 3'b010);
            end
            if (i == 3) begin
                check("mul_rd", bus_a.out_rd, 5'd3);
                check("b_mul_cnt", cnt_b, 2'd1);
            end
        end
        idle();
        cycle();
        check("cnt_a_final", cnt_a, 16'd5);
        check("cnt_b_saturated", cnt_b, 2'd3);

        // Stall: two words fill M and S, the third waits until execute drains.
        bus_a.out_ready = 1'b0;
        drive(32'h00100113, 32'h2000, 32'h1, 1'b0, 1'b0);
        cycle();
        drive(32'h00200113, 32'h2004, 32'h2, 1'b0, 1'b0);
        cycle();
        check("full_state", state_a, BUF_FULL);
        check("full_in_ready", bus_a.in_ready, 1'b0);
        drive(32'h00300113, 32'h2008, 32'h3, 1'b0, 1'b0);
        cycle();
        check("stall_head_pc", bus_a.out_pc, 32'h2000);
        bus_a.out_ready = 1'b1;
        cycle();
        check("drain1_pc", bus_a.out_pc, 32'h2004);
        cycle();
        check("drain2_pc", bus_a.out_pc, 32'h2008);
        idle();
        cycle();
        check("drained_state", state_a, BUF_EMPTY);

        // Flush while full with a word offered in the same cycle.
        bus_a.out_ready = 1'b0;
        drive(32'h00400113, 32'h3000, 32'h4, 1'b0, 1'b0);
        cycle();
        drive(32'h00500113, 32'h3004, 32'h5, 1'b0, 1'b0);
        cycle();
        flush = 1'b1;
        drive(32'h00000000, 32'h3008, 32'h0, 1'b1, 1'b1);
        cycle();
        check("flush_out_valid", bus_a.out_valid, 1'b0);
        check("flush_in_ready", bus_a.in_ready, 1'b1);
        check("flush_cnt", cnt_a, 16'd5);
        idle();
        cycle();

        // Random streaming of addi words with random stalls and rare flushes.
        for (int n = 0; n < 400; n++) begin
            logic [11:0] imm12;
            imm12 = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0)
                drive({imm12, 5'($urandom_range(0, 31)), 3'b000, 5'($urandom_range(0, 31)), 7'h13},
                      32'($urandom), {{20{imm12[11]}}, imm12}, 1'b0, 1'b0);
            else
                idle();
            bus_a.out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 31) == 0);
            cycle();
        end
        idle();
        bus_a.out_ready = 1'b1;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
